// File: rtl/notepad_pkg.sv
// Shared definitions for the notepad cursor controller: command codes,
// controller states and the fixed column geometry.
package notepad_pkg;

    localparam int         COLS     = 64;
    localparam logic [5:0] COL_LAST = 6'(COLS - 1);

    typedef enum logic [1:0] {
        C_CHAR      = 2'b00,
        C_NEWLINE   = 2'b01,
        C_HOME      = 2'b10,
        C_CLEAR_ALL = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        NEWLINE = 3'd2,
        HOME    = 3'd3,
        ZERO    = 3'd4,
        SWEEP   = 3'd5,
        DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/counter_6bit.sv
// Free-running 6-bit up-counter with synchronous clear (dominant) and enable.
module counter_6bit (
    input  logic       CLK,
    input  logic       en,
    input  logic       clr,
    output logic [5:0] q
);

    always_ff @(posedge CLK) begin
        if (clr)
            q <= '0;
        else if (en)
            q <= q + 6'd1;
    end

endmodule

// File: rtl/notepad_cursor_ctrl.sv
// Cursor/write controller for a ROWS x 64 character text buffer: places
// characters, handles newline/home, and sweeps BLANK over the whole buffer.
module notepad_cursor_ctrl
    import notepad_pkg::*;
#(
    parameter int         ROWS  = 48,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD,
    input  logic [7:0]  CMD_DATA,
    output logic        WR_EN,
    output logic [11:0] WR_ADDR,
    output logic [7:0]  WR_DATA,
    output logic [5:0]  ROW,
    output logic [5:0]  COL,
    output logic        BUSY
);

    localparam logic [5:0] ROW_LAST = 6'(ROWS - 1);

    state_t     state;
    cmd_t       cmd_q;
    logic [7:0] data_q;
    logic       wr_en_q;
    logic       busy_q;

    logic accept;
    logic col_last;
    logic row_last;
    logic col_en;
    logic col_clr;
    logic row_en;
    logic row_clr;

    assign CMD_READY = (state == IDLE) && !CLR;
    assign accept    = CMD_VALID && CMD_READY;
    assign col_last  = (COL == COL_LAST);
    assign row_last  = (ROW == ROW_LAST);

    // Counter controls; clear dominates enable inside the counter, which
    // is how the last row wraps back to 0.
    always_comb begin
        col_en  = 1'b0;
        col_clr = CLR;
        row_en  = 1'b0;
        row_clr = CLR;
        case (state)
            WRITE, SWEEP: begin
                col_en = 1'b1;
                if (col_last) begin
                    row_en = 1'b1;
                    if (row_last)
                        row_clr = 1'b1;
                end
            end
            NEWLINE: begin
                col_clr = 1'b1;
                row_en  = 1'b1;
                if (row_last)
                    row_clr = 1'b1;
            end
            HOME, ZERO, DONE: begin
                col_clr = 1'b1;
                row_clr = 1'b1;
            end
            default: ;
        endcase
    end

    counter_6bit u_col (
        .CLK (CLK),
        .en  (col_en),
        .clr (col_clr),
        .q   (COL)
    );

    counter_6bit u_row (
        .CLK (CLK),
        .en  (row_en),
        .clr (row_clr),
        .q   (ROW)
    );

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state   <= IDLE;
            cmd_q   <= C_CHAR;
            data_q  <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd_q  <= cmd_t'(CMD);
                        data_q <= CMD_DATA;
                        busy_q <= 1'b1;
                        case (cmd_t'(CMD))
                            C_CHAR: begin
                                state   <= WRITE;
                                wr_en_q <= 1'b1;
                            end
                            C_NEWLINE:   state <= NEWLINE;
                            C_HOME:      state <= HOME;
                            C_CLEAR_ALL: state <= ZERO;
                            default:     state <= IDLE;
                        endcase
                    end
                end
                WRITE: begin
                    state   <= IDLE;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
                NEWLINE, HOME, DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                ZERO: begin
                    state   <= SWEEP;
                    wr_en_q <= 1'b1;
                end
                SWEEP: begin
                    if (row_last && col_last) begin
                        state   <= DONE;
                        wr_en_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    wr_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Address and data are forced to zero whenever no write is strobed,
    // so the bus is quiet during reset and between writes.
    assign WR_EN   = wr_en_q;
    assign WR_ADDR = wr_en_q ? {ROW, COL} : 12'h000;
    assign WR_DATA = !wr_en_q ? 8'h00 : ((cmd_q == C_CLEAR_ALL) ? BLANK : data_q);
    assign BUSY    = busy_q;

endmodule

// File: tb/tb_notepad_cursor_ctrl.sv
// Self-checking bench for notepad_cursor_ctrl using a linear cursor-position
// reference model (pos = row*64 + col, modulo the buffer size).
module tb_notepad_cursor_ctrl;

    localparam int ROWS  = 48;
    localparam int CELLS = ROWS * 64;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic [1:0]  CMD;
    logic [7:0]  CMD_DATA;
    logic        WR_EN;
    logic [11:0] WR_ADDR;
    logic [7:0]  WR_DATA;
    logic [5:0]  ROW;
    logic [5:0]  COL;
    logic        BUSY;

    int tests = 0;
    int fails = 0;
    int pos   = 0;

    notepad_cursor_ctrl #(.ROWS(ROWS), .BLANK(8'h20)) dut (
        .CLK       (CLK),
        .CLR       (CLR),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD       (CMD),
        .CMD_DATA  (CMD_DATA),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .ROW       (ROW),
        .COL       (COL),
        .BUSY      (BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one non-clear command from an idle negedge and follow it to idle.
    task automatic send(input logic [1:0] c, input logic [7:0] d);
        check("ready_idle", CMD_READY, 1);
        CMD       = c;
        CMD_DATA  = d;
        CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        check("busy", BUSY, 1);
        check("ready_busy", CMD_READY, 0);
        if (c == 2'b00) begin
            check("wr_en", WR_EN, 1);
            check("wr_addr", WR_ADDR, pos);
            check("wr_data", WR_DATA, d);
            pos = (pos + 1) % CELLS;
        end else begin
            check("wr_en_off", WR_EN, 0);
            if (c == 2'b01)
                pos = ((pos / 64 + 1) % ROWS) * 64;
            else
                pos = 0;
        end
        @(negedge CLK);
        check("ready_back", CMD_READY, 1);
        check("row", ROW, pos / 64);
        check("col", COL, pos % 64);
    endtask

    initial begin
        int wcount;
        int ready_low;
        int addr_err;
        int data_err;
        int stray;
        int r;
        logic [7:0] d;

        CLR       = 1'b1;
        CMD_VALID = 1'b0;
        CMD       = 2'b00;
        CMD_DATA  = 8'h00;

        // Reset values before any clock edge.
        #1;
        check("rst_ready", CMD_READY, 0);
        check("rst_wr_en", WR_EN, 0);
        check("rst_wr_addr", WR_ADDR, 0);
        check("rst_wr_data", WR_DATA, 0);
        check("rst_busy", BUSY, 0);
        @(negedge CLK);
        check("rst_row", ROW, 0);
        check("rst_col", COL, 0);
        check("rst_ready_hold", CMD_READY, 0);
        CLR = 1'b0;
        #1;
        check("rel_ready", CMD_READY, 1);
        check("rel_busy", BUSY, 0);
        pos = 0;

        send(2'b00, 8'h41);

        // A full line of characters wraps onto row 1.
        send(2'b10, 8'h00);
        for (int i = 0; i < 64; i++) send(2'b00, 8'($urandom));

        // Last cell of the buffer wraps to the origin; newline on last row too.
        send(2'b10, 8'h00);
        for (int i = 0; i < ROWS - 1; i++) send(2'b01, 8'h00);
        for (int i = 0; i < 63; i++) send(2'b00, 8'($urandom));
        send(2'b00, 8'h7E);
        for (int i = 0; i < ROWS - 1; i++) send(2'b01, 8'($urandom));
        send(2'b01, 8'h00);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            send((r < 7) ? 2'b00 : ((r < 9) ? 2'b01 : 2'b10), 8'($urandom));
        end

        // Clear-all from (5,10) with a CHAR held valid across the sweep.
        send(2'b10, 8'h00);
        for (int i = 0; i < 5; i++) send(2'b01, 8'h00);
        for (int i = 0; i < 10; i++) send(2'b00, 8'($urandom));
        check("pre_clear_row", ROW, 5);
        check("pre_clear_col", COL, 10);
        CMD       = 2'b11;
        CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD      = 2'b00;
        CMD_DATA = 8'h5A;
        wcount = 0; ready_low = 0; addr_err = 0; data_err = 0;
        for (int n = 0; n < 4000 && CMD_READY !== 1'b1; n++) begin
            ready_low++;
            if (WR_EN === 1'b1) begin
                if (WR_ADDR !== 12'(wcount)) addr_err++;
                if (WR_DATA !== 8'h20) data_err++;
                wcount++;
            end
            @(negedge CLK);
        end
        check("sweep_writes", wcount, CELLS);
        check("sweep_addr_errs", addr_err, 0);
        check("sweep_data_errs", data_err, 0);
        check("sweep_ready_low", ready_low, CELLS + 2);
        check("sweep_end_row", ROW, 0);
        check("sweep_end_col", COL, 0);
        check("sweep_end_busy", BUSY, 0);
        pos = 0;
        for (int k = 0; k < 6; k++) begin
            d = CMD_DATA;
            @(negedge CLK);
            check("held_wr_en", WR_EN, 1);
            check("held_wr_addr", WR_ADDR, pos);
            check("held_wr_data", WR_DATA, d);
            pos = (pos + 1) % CELLS;
            CMD_DATA = 8'($urandom);
            @(negedge CLK);
            check("held_ready", CMD_READY, 1);
            check("held_gap", WR_EN, 0);
        end
        CMD_VALID = 1'b0;
        check("held_row", ROW, pos / 64);
        check("held_col", COL, pos % 64);

        // Reset pulse during sweep write 100 aborts with no resume.
        CMD       = 2'b11;
        CMD_VALID = 1'b1;
        @(negedge CLK);
        CMD_VALID = 1'b0;
        wcount = 0;
        for (int n = 0; n < 500; n++) begin
            if (WR_EN === 1'b1) wcount++;
            if (wcount == 100) break;
            @(negedge CLK);
        end
        check("abort_reach", wcount, 100);
        CLR = 1'b1;
        #1;
        check("abort_wr_en", WR_EN, 0);
        check("abort_wr_addr", WR_ADDR, 0);
        check("abort_ready", CMD_READY, 0);
        @(negedge CLK);
        check("abort_row", ROW, 0);
        check("abort_col", COL, 0);
        check("abort_busy", BUSY, 0);
        CLR = 1'b0;
        #1;
        check("abort_rel_ready", CMD_READY, 1);
        stray = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge CLK);
            if (WR_EN !== 1'b0) stray++;
        end
        check("abort_no_resume", stray, 0);
        pos = 0;
        send(2'b00, 8'h42);
        send(2'b01, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/notepad_cursor_ctrl.md
NOTEPAD_CURSOR_CTRL -- requirements
Module: notepad_cursor_ctrl

Interface
REQ-001 Parameter ROWS, default 48, number of text rows (2..64); column count fixed at 64.
REQ-002 Parameter BLANK, default 8'h20, character written during clear-all.
REQ-003 CLK  in  1  sole clock; all state updates on posedge CLK.
REQ-004 CLR  in  1  reset, asynchronous, active-high.
REQ-005 CMD_VALID  in  1  command offered this cycle.
REQ-006 CMD_READY  out  1  controller able to accept a command.
REQ-007 CMD  in  2  00 CHAR, 01 NEWLINE, 10 HOME, 11 CLEAR_ALL.
REQ-008 CMD_DATA  in  8  character code; used only for CHAR.
REQ-009 WR_EN  out  1  write strobe to the text buffer.
REQ-010 WR_ADDR  out  12  {row[5:0], col[5:0]} of the write.
REQ-011 WR_DATA  out  8  character to write.
REQ-012 ROW  out  6, COL  out  6  current cursor position.
REQ-013 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-014 Cursor position SHALL be held in two 6-bit up-counters (row, column) with synchronous EN and synchronous clear; the controller SHALL drive only their EN and clear.
REQ-015 A command is accepted when CMD_VALID and CMD_READY are both high at a posedge; CMD and CMD_DATA SHALL be captured only then.
REQ-016 CMD_READY SHALL be high only in IDLE; it SHALL be combinational from state, never from CMD_VALID.
REQ-017 FSM states: IDLE, WRITE, NEWLINE, HOME, ZERO, SWEEP, DONE.
REQ-018 IDLE -> WRITE/NEWLINE/HOME/ZERO on accept of CHAR/NEWLINE/HOME/CLEAR_ALL; otherwise stay.
REQ-019 WRITE (1 cycle): WR_EN=1, WR_ADDR={ROW,COL}, WR_DATA=captured char; column +1; -> IDLE.
REQ-020 Column wrap in WRITE: COL=63 -> COL=0 and row advances per REQ-021.
REQ-021 Row advance: ROW<ROWS-1 -> ROW+1; ROW=ROWS-1 -> ROW=0.
REQ-022 NEWLINE (1 cycle): column cleared, row advanced per REQ-021, WR_EN=0; -> IDLE.
REQ-023 HOME (1 cycle): row and column cleared; -> IDLE.
REQ-024 ZERO (1 cycle): row and column cleared, WR_EN=0; -> SWEEP.
REQ-025 SWEEP: every cycle WR_EN=1, WR_DATA=BLANK, WR_ADDR={ROW,COL}, column +1; at COL=63 row +1; at ROW=ROWS-1 and COL=63 -> DONE. Exactly ROWS*64 write cycles.
REQ-026 DONE (1 cycle): row and column cleared; -> IDLE.
REQ-027 Latency from accept edge to CMD_READY high: CHAR/NEWLINE/HOME 1 cycle; CLEAR_ALL ROWS*64+2 cycles.
REQ-028 WR_EN SHALL be 0 in IDLE, NEWLINE, HOME, ZERO, DONE.
REQ-029 CMD_VALID held high across a busy period SHALL NOT be accepted until CMD_READY is high; back-to-back accepts every 2 cycles SHALL be supported.

Reset
REQ-030 CLR high SHALL force state IDLE and clear captured CMD/CMD_DATA asynchronously.
REQ-031 While CLR is high, counter clear SHALL be asserted so ROW=COL=0 from the first posedge during reset.
REQ-032 Output values during/after reset: CMD_READY=0 while CLR high, 1 after release; WR_EN=0, WR_ADDR=0, WR_DATA=0, BUSY=0.
REQ-033 CLR asserted mid-SWEEP SHALL abort the sweep with no further writes; no resume after release.

Structure
REQ-034 Command encodings, state encoding and the 64-column constant SHALL live in shared package notepad_pkg.
REQ-035 Row and column counters SHALL each be an instance of the existing counter_6bit module; no other sub-modules.

Verification
REQ-036 Reset, then CHAR 'A'(8'h41) at (0,0) -> one WR_EN with WR_ADDR=12'h000, WR_DATA=8'h41; next COL=1, ROW=0.
REQ-037 64 CHARs from (0,0) -> last write WR_ADDR=12'h03F; then ROW=1, COL=0.
REQ-038 Cursor at (47,63), ROWS=48, CHAR -> write at 12'hBFF; then ROW=0, COL=0; NEWLINE at row 47 -> ROW=0, COL=0.
REQ-039 CLEAR_ALL from (5,10), ROWS=48 -> exactly 3072 WR_EN cycles, addresses 12'h000..12'hBFF in order, WR_DATA=8'h20; CMD_READY low for 3074 cycles; ends at (0,0).
REQ-040 CMD_VALID held high with CHARs during CLEAR_ALL -> none accepted until CMD_READY returns; then one per 2 cycles.
REQ-041 CLR pulsed at sweep write 100 -> WR_EN low immediately, ROW=COL=0 after next posedge, CMD_READY high after release.
